// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with dead-time, double buffer and blink
//
// Time-multiplexes one shared character decoder across DIGITS common-anode digits.
// Each digit slot is REFRESH_DIV clocks: BLANK_CYC clocks with every anode off,
// then the selected anode driven low for the remainder of the slot.
//
// Ports
//   clk         in   1               rising-edge clock
//   rst_n       in   1               asynchronous active-low reset
//   load        in   1               capture codes_in / blink_mask into shadow registers
//   codes_in    in   5*DIGITS        digit codes, digit i = codes_in[5*i+4:5*i]
//   blink_mask  in   DIGITS          1 = digit i blinks
//   code_out    out  5               code of the selected digit, to the shared decoder
//   an          out  DIGITS          anode enables, active-low, at most one bit low
//   digit_idx   out  $clog2(DIGITS)  currently selected digit
//   scan_done   out  1               one-cycle pulse after the index wraps to 0
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int BLINK_SCANS = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [5*DIGITS-1:0]       codes_in,
  input  logic [DIGITS-1:0]         blink_mask,
  output logic [4:0]                code_out,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      scan_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(BLINK_SCANS) + 1;

  localparam logic [4:0]    BLANK_CODE = 5'b10110;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(BLINK_SCANS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][4:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0][4:0]   active_q, active_d;
  logic [DIGITS-1:0]        smask_q, smask_d;
  logic [DIGITS-1:0]        amask_q, amask_d;
  logic                     phase_q, phase_d;   // 1 = blinking digits visible
  logic [SW-1:0]            scnt_q, scnt_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [4:0]               code_q, code_d;
  logic                     done_q;
  logic                     wrap;

  assign code_out  = code_q;
  assign an        = an_q;
  assign digit_idx = idx_q;
  assign scan_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= {DIGITS{BLANK_CODE}};
      active_q <= {DIGITS{BLANK_CODE}};
      smask_q  <= '0;
      amask_q  <= '0;
      phase_q  <= 1'b1;
      scnt_q   <= '0;
      an_q     <= '1;
      code_q   <= BLANK_CODE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      smask_q  <= smask_d;
      amask_q  <= amask_d;
      phase_q  <= phase_d;
      scnt_q   <= scnt_d;
      an_q     <= an_d;
      code_q   <= code_d;
      done_q   <= wrap;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    wrap     = 1'b0;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_q == CNT_LAST) begin
        state_d = ST_BLANK;
        wrap    = (idx_q == IDX_LAST);
        idx_d   = wrap ? '0 : idx_q + 1'b1;
      end
      default:  state_d = ST_BLANK;
    endcase

    shadow_d = shadow_q;
    smask_d  = smask_q;
    active_d = active_q;
    amask_d  = amask_q;
    phase_d  = phase_q;
    scnt_d   = scnt_q;
    if (load) begin
      shadow_d = codes_in;
      smask_d  = blink_mask;
    end
    // Frames and blink phase only change at the scan boundary; taking the
    // shadow's next value lets a load on the wrap edge reach the display directly.
    if (wrap) begin
      active_d = shadow_d;
      amask_d  = smask_d;
      if (scnt_q == SCAN_LAST) begin
        scnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        scnt_d  = scnt_q + 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so code_out changes on the
  // same edge as digit_idx, a full blank period before the anode enables.
  always_comb begin
    an_d = '1;
    if (state_d == ST_DRIVE) an_d[idx_d] = 1'b0;
    code_d = active_d[idx_d];
    if (!phase_d && amask_d[idx_d]) code_d = BLANK_CODE;
  end

endmodule
